// File: rtl/ecc_ladder_seq.sv
// ecc_ladder_seq: Montgomery-ladder control sequencer for 256-bit scalar
// multiplication. Walks the scalar MSB-first. Each iteration launches the add
// and double units together, waits for both of them to finish, and commits the
// two results. The iteration count is fixed, so the run time does not depend
// on the scalar value.
`timescale 1ns/1ps
module ecc_ladder_seq #(
  parameter int K_WIDTH = 256,
  parameter int IDX_W   = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [K_WIDTH-1:0] i_k,
  input  logic               i_add_done,
  input  logic               i_dbl_done,
  output logic               o_busy,
  output logic               o_load_init,
  output logic               o_add_start,
  output logic               o_dbl_start,
  output logic               o_kbit,
  output logic               o_wr_en,
  output logic [IDX_W-1:0]   o_bit_idx,
  output logic               o_done,
  output logic               o_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_COMMIT, S_DONE
  } state_t;

  state_t             state, state_nx;
  // The scalar is held left-aligned and shifted once per commit, so the MSB
  // is always the bit at index idx. This avoids a wide 256:1 bit-select mux.
  logic [K_WIDTH-1:0] k_reg;
  logic [IDX_W-1:0]   idx;
  logic               add_seen, dbl_seen;
  logic [WD_W-1:0]    wd_cnt;
  logic               err_q;
  logic               both_done, wd_hit;

  // A done pulse that arrives in the same cycle counts toward completion.
  assign both_done = (add_seen | i_add_done) & (dbl_seen | i_dbl_done);
  assign wd_hit    = (wd_cnt == WD_W'(TIMEOUT - 1));

  // State register plus the ladder bookkeeping (scalar, index, flags, watchdog)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      k_reg    <= '0;
      idx      <= '0;
      add_seen <= 1'b0;
      dbl_seen <= 1'b0;
      wd_cnt   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (i_start) begin
          k_reg <= i_k;
          idx   <= IDX_W'(K_WIDTH - 1);
          err_q <= 1'b0;
        end
        S_ISSUE: begin
          add_seen <= 1'b0;
          dbl_seen <= 1'b0;
          wd_cnt   <= '0;
        end
        S_WAIT: begin
          if (i_add_done) add_seen <= 1'b1;
          if (i_dbl_done) dbl_seen <= 1'b1;
          if (!both_done) begin
            if (wd_hit) err_q  <= 1'b1;
            else        wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_COMMIT: if (idx != '0) begin
          idx   <= idx - 1'b1;
          k_reg <= k_reg << 1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and Moore strobes; nothing is exposed while idle
  always_comb begin
    state_nx    = state;
    o_busy      = (state != S_IDLE);
    o_load_init = 1'b0;
    o_add_start = 1'b0;
    o_dbl_start = 1'b0;
    o_wr_en     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_kbit      = 1'b0;
    o_bit_idx   = '0;
    if (state != S_IDLE) begin
      o_kbit    = k_reg[K_WIDTH-1];
      o_bit_idx = idx;
    end
    unique case (state)
      S_IDLE:  if (i_start) state_nx = S_INIT;
      S_INIT: begin
        o_load_init = 1'b1;
        state_nx    = S_ISSUE;
      end
      S_ISSUE: begin
        o_add_start = 1'b1;
        o_dbl_start = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: begin
        if (both_done)   state_nx = S_COMMIT;
        else if (wd_hit) state_nx = S_DONE;
      end
      S_COMMIT: begin
        o_wr_en  = 1'b1;
        state_nx = (idx == '0) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        o_done   = 1'b1;
        o_err    = err_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ecc_ladder_seq.sv
// Scoreboard bench for ecc_ladder_seq. A timing model derived from the ladder
// rules fills expected issue, commit and done queues at start. A monitor pops
// and compares those entries as the DUT strobes. Emulated add and double units
// answer with per-iteration latencies that are fixed, skewed or random.
`timescale 1ns/1ps
module tb_ecc_ladder_seq;
  localparam int KW = 256;
  localparam int IW = 9;
  localparam int TO = 16;

  typedef struct { int cyc; int kbit; int idx; int err; } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start_m = 1'b0, start_s = 1'b0;
  logic [KW-1:0] k_m = '0, k_s = '0;
  logic          add_dn = 1'b0, dbl_dn = 1'b0;
  logic          o_busy, o_load_init, o_add_start, o_dbl_start, o_kbit, o_wr_en, o_done, o_err;
  logic [IW-1:0] o_bit_idx;

  ecc_ladder_seq #(.K_WIDTH(KW), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start_m | start_s),
    .i_k(start_s ? k_s : k_m), .i_add_done(add_dn), .i_dbl_done(dbl_dn),
    .o_busy(o_busy), .o_load_init(o_load_init), .o_add_start(o_add_start),
    .o_dbl_start(o_dbl_start), .o_kbit(o_kbit), .o_wr_en(o_wr_en),
    .o_bit_idx(o_bit_idx), .o_done(o_done), .o_err(o_err)
  );

  ev_t q_iss[$], q_wr[$], q_done[$];
  int  nchk = 0, nerr = 0;
  int  cyc = 0, start_cyc = 0;
  int  mode = 4, it = 0;
  bit  mon_en = 1'b0, chk_idle = 1'b0;
  int  la[KW], ld[KW];

  localparam logic [KW-1:0] K_NOM =
    256'hd83715f8_2c4b9e01_5a7f3c22_91e0b6d4_7c3a58f1_0e9d24b7_a6c13f58_eed765ed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - start_cyc);
    end
  endtask

  task automatic fail(input string nm);
    nchk++; nerr++;
    $display("FAIL %s: unexpected strobe at cycle %0d", nm, cyc - start_cyc);
  endtask

  function automatic logic [KW-1:0] rand256();
    logic [KW-1:0] r = '0;
    for (int i = 0; i < KW / 32; i++) r = {r[KW-33:0], 32'($urandom)};
    return r;
  endfunction

  // Modes: 0 both L=1; 1 skewed 3/7 alternating; 2 spurious inputs (add 1, dbl 2);
  // 3 double unit dead; 4 random noise (reset); 5 random latencies
  function automatic int lat_a(input int i);
    case (mode)
      1: return (i % 2 == 0) ? 3 : 7;
      5: return la[i % KW];
      default: return 1;
    endcase
  endfunction

  function automatic int lat_d(input int i);
    case (mode)
      1: return (i % 2 == 0) ? 7 : 3;
      2: return 2;
      5: return ld[i % KW];
      default: return 1;
    endcase
  endfunction

  // Expected event timeline: ISSUE at t, COMMIT at t+L+1, next ISSUE at t+L+2
  task automatic build_model(input logic [KW-1:0] k);
    int  t = 2;
    int  l;
    ev_t e;
    q_iss.delete(); q_wr.delete(); q_done.delete();
    for (int i = 0; i < KW; i++) begin
      e.cyc = t; e.kbit = int'(k[KW-1-i]); e.idx = KW - 1 - i; e.err = 0;
      q_iss.push_back(e);
      if (mode == 3) begin
        e.cyc = t + 1 + TO; e.err = 1;
        q_done.push_back(e);
        return;
      end
      l = (lat_a(i) > lat_d(i)) ? lat_a(i) : lat_d(i);
      e.cyc = t + l + 1;
      q_wr.push_back(e);
      t = t + l + 2;
    end
    e.cyc = t; e.err = 0; e.kbit = 0; e.idx = 0;
    q_done.push_back(e);
  endtask

  // Emulated point-add / point-double units plus spurious-input injection
  initial begin : units
    int  a_cnt = 0, d_cnt = 0, dup_cnt = 0;
    bit  ap, dp;
    forever begin
      @(negedge clk);
      ap = 1'b0; dp = 1'b0;
      if (a_cnt > 0)   begin a_cnt--;   if (a_cnt == 0)   ap = 1'b1; end
      if (d_cnt > 0)   begin d_cnt--;   if (d_cnt == 0)   dp = 1'b1; end
      if (dup_cnt > 0) begin dup_cnt--; if (dup_cnt == 0) ap = 1'b1; end
      if (o_add_start) begin
        a_cnt = lat_a(it);
        d_cnt = (mode == 3) ? 0 : lat_d(it);
        if (mode == 2) begin
          dup_cnt = lat_a(it) + 1;
          ap = 1'b1; dp = 1'b1;
        end
        it++;
      end
      if (mode == 2 && o_wr_en) begin ap = 1'b1; dp = 1'b1; end
      if (mode == 4) begin ap = 1'($urandom); dp = 1'($urandom); end
      start_s = (mode == 2) && o_busy && ($urandom_range(0, 15) == 0);
      k_s     = rand256();
      add_dn  = ap;
      dbl_dn  = dp;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes
  initial begin : monitor
    int  rel;
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        rel = cyc - start_cyc;
        if (chk_idle) begin check("busy_fall", o_busy, 0); chk_idle = 1'b0; end
        if (!o_busy)
          check("idle_outs", {o_load_init, o_add_start, o_dbl_start, o_kbit,
                              o_wr_en, o_bit_idx, o_done, o_err}, 0);
        if (o_load_init) check("init_cyc", rel, 1);
        if (o_add_start || o_dbl_start) begin
          if (q_iss.size() == 0) fail("issue");
          else begin
            e = q_iss.pop_front();
            check("issue_cyc", rel, e.cyc);
            check("issue_pair", {o_add_start, o_dbl_start}, 2'b11);
            check("issue_kbit", o_kbit, e.kbit);
            check("issue_idx", o_bit_idx, e.idx);
          end
        end
        if (o_wr_en) begin
          if (q_wr.size() == 0) fail("wr_en");
          else begin
            e = q_wr.pop_front();
            check("wr_cyc", rel, e.cyc);
            check("wr_kbit", o_kbit, e.kbit);
            check("wr_idx", o_bit_idx, e.idx);
          end
        end
        if (o_done) begin
          if (q_done.size() == 0) fail("done");
          else begin
            e = q_done.pop_front();
            check("done_cyc", rel, e.cyc);
            check("done_err", o_err, e.err);
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic launch(input logic [KW-1:0] k, input int m);
    mode = m; it = 0;
    for (int i = 0; i < KW; i++) begin
      la[i] = $urandom_range(1, 6);
      ld[i] = $urandom_range(1, 6);
    end
    build_model(k);
    start_m = 1'b1; k_m = k; start_cyc = cyc;
    @(negedge clk);
    start_m = 1'b0; k_m = rand256();
  endtask

  // Run to completion; returns in the first IDLE cycle so the next start is back-to-back
  task automatic run(input logic [KW-1:0] k, input int m);
    int n = 0;
    launch(k, m);
    while (q_done.size() != 0 && n < 4000) begin @(negedge clk); n++; end
    check("run_finished", q_done.size(), 0);
    @(negedge clk);
    check("issues_left", q_iss.size(), 0);
    check("wr_left", q_wr.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    // Reset held three cycles with random inputs
    repeat (3) begin
      @(negedge clk);
      start_m = 1'($urandom); k_m = rand256();
    end
    check("rst_busy", o_busy, 0);
    check("rst_outs", {o_load_init, o_add_start, o_dbl_start, o_kbit, o_wr_en,
                       o_bit_idx, o_done, o_err}, 0);
    mode = 0; start_m = 1'b0; rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    run(K_NOM, 0);          // nominal: done at 770
    run(KW'(1), 1);         // skewed dones: done at 2306
    run(K_NOM, 2);          // spurious starts and done pulses
    run(rand256(), 5);      // random latencies
    run(rand256(), 5);
    run(rand256(), 3);      // watchdog: done+err at 19

    // Reset in the middle of iteration 100 (bit 155)
    launch(K_NOM, 0);
    n = 0;
    while (!(o_busy && o_bit_idx == IW'(155)) && n < 2000) begin @(negedge clk); n++; end
    check("midrst_reach", o_bit_idx, 155);
    mon_en = 1'b0;
    q_iss.delete(); q_wr.delete(); q_done.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {o_busy, o_load_init, o_add_start, o_dbl_start, o_kbit,
                          o_wr_en, o_bit_idx, o_done, o_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (30) @(negedge clk);
    run('0, 0);             // k=0 after reset: done at 770, kbit always 0

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
